decode_ctrl_seq: RTL

DECODE_CTRL_SEQ -- requirements
Module: decode_ctrl_seq

---
 rtl/decode_ctrl_seq.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/decode_ctrl_seq.sv
// decode_ctrl_seq
// Decodes a 32-bit instruction word into registered datapath controls behind a
// valid/ready handshake. Most opcodes produce controls one cycle after accept.
// M-extension ops (MUL/DIV) hold the block busy until MULDIV_LAT cycles after
// accept, then present their controls.
//
// Parameters
//   MULDIV_LAT      cycles from accept to out_valid for MUL/DIV, legal 2..15
//   EN_MULDIV       1: opcode 0110011 with funct7 0000001 decodes as MUL/DIV
//                   0: that encoding is treated as illegal
//   EN_ILLEGAL_CHK  1: bad opcode/funct3 combinations raise Illegal
//                   0: unknown opcodes give all-zero controls, Illegal=0
//
// Ports
//   clk, reset_n           clock (rising edge), synchronous active-low reset
//   in_valid, instr        instruction presented / instruction word
//   in_ready               accept possible this cycle
//   flush                  discard held and in-flight decode
//   out_valid, out_ready   registered controls valid / downstream consumes
//   RegWrite .. Illegal    registered decode controls
//   busy                   MUL/DIV in flight
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | accepting; holds the current output until it is consumed
// MD_WAIT | MUL/DIV in flight; counter runs down to the result cycle
module decode_ctrl_seq #(
    parameter int MULDIV_LAT     = 4,
    parameter bit EN_MULDIV      = 1'b1,
    parameter bit EN_ILLEGAL_CHK = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [31:0] instr,
    output logic        in_ready,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        RegWrite,
    output logic [2:0]  ImmSrc,
    output logic        ALUSrc,
    output logic        MemWrite,
    output logic [2:0]  ResultSrc,
    output logic [1:0]  ALUOp,
    output logic        PCResultSrc,
    output logic        MulDiv,
    output logic        Illegal,
    output logic        busy
);

    typedef enum logic {
        IDLE    = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    // MULDIV_LAT must lie in 2..15 so the load value fits the 4-bit counter.
    // Accept edge plus (LAT-2) countdown edges plus the completion edge gives
    // out_valid exactly MULDIV_LAT cycles after accept.
    localparam logic [3:0] CNT_LOAD = 4'(MULDIV_LAT - 2);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ov_q, ov_d;
    // {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, ALUOp, PCResultSrc, MulDiv, Illegal}
    logic [13:0] ctl_q, ctl_d;

    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] dec_row;
    logic        dec_unknown;
    logic        dec_bad;
    logic        dec_md;
    logic        dec_ill;
    logic [11:0] dec_ctrl;
    logic        dec_muldiv;
    logic        accept;
    logic        unused_instr;

    assign op           = instr[6:0];
    assign funct3       = instr[14:12];
    assign funct7       = instr[31:25];
    assign unused_instr = ^{instr[24:15], instr[11:7]};

    always_comb begin
        dec_row     = '0;
        dec_unknown = 1'b0;
        dec_bad     = 1'b0;
        dec_md      = 1'b0;
        case (op)
            OP_LOAD: begin
                dec_row = 12'b1_000_1_0_001_00_0;
                dec_bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OP_STORE: begin
                dec_row = 12'b0_001_1_1_000_00_0;
                dec_bad = (funct3 >= 3'b011);
            end
            OP_R: begin
                if (funct7 == 7'b0000001) begin
                    if (EN_MULDIV) begin
                        dec_row = 12'b1_000_0_0_101_10_0;
                        dec_md  = 1'b1;
                    end else begin
                        dec_unknown = 1'b1;
                    end
                end else begin
                    dec_row = 12'b1_000_0_0_000_10_0;
                end
            end
            OP_BRANCH: begin
                dec_row = 12'b0_010_0_0_000_01_0;
                dec_bad = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OP_I:     dec_row = 12'b1_000_1_0_000_10_0;
            OP_JAL:   dec_row = 12'b1_011_0_0_010_00_0;
            OP_AUIPC: dec_row = 12'b1_100_0_0_100_00_0;
            OP_LUI:   dec_row = 12'b1_100_0_0_110_00_0;
            OP_JALR: begin
                dec_row = 12'b1_000_1_0_010_10_1;
                dec_bad = (funct3 != 3'b000);
            end
            default: dec_unknown = 1'b1;
        endcase
    end

    // Unknown encodings always zero the controls; funct3 violations only
    // matter when the illegal check is enabled.
    assign dec_ill    = EN_ILLEGAL_CHK && (dec_unknown || dec_bad);
    assign dec_ctrl   = (dec_unknown || dec_ill) ? 12'b0 : dec_row;
    assign dec_muldiv = dec_md && !dec_ill;

    assign in_ready = reset_n && (state_q == IDLE) && (!ov_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ov_d    = ov_q;
        ctl_d   = ctl_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            ov_d    = 1'b0;
            ctl_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        ctl_d = {dec_ctrl, dec_muldiv, dec_ill};
                        if (dec_muldiv) begin
                            state_d = MD_WAIT;
                            cnt_d   = CNT_LOAD;
                            ov_d    = 1'b0;
                        end else begin
                            ov_d = 1'b1;
                        end
                    end else if (ov_q && out_ready) begin
                        ov_d = 1'b0;
                    end
                end
                MD_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_d = IDLE;
                        ov_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ov_q    <= ov_d;
            ctl_q   <= ctl_d;
        end
    end

    assign out_valid = ov_q;
    assign busy      = (state_q == MD_WAIT);
    assign {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, ALUOp, PCResultSrc, MulDiv, Illegal} = ctl_q;

endmodule
